// File: rtl/jk_flip_flop.sv
// Single-bit edge-triggered JK flip-flop with complementary outputs.
//
// On each rising clk edge the JK control selects the next state:
//   00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle.
// An asynchronous active-low reset loads RESET_VALUE at any time.
//
// Parameters:
//   RESET_VALUE - value of q while rst_n is low (qb = ~RESET_VALUE)
//
// Ports:
//   clk   - clock; all non-reset state changes occur on its rising edge
//   rst_n - asynchronous active-low reset
//   JK    - control, JK[1] = J, JK[0] = K
//   q     - registered state
//   qb    - complement of q, derived combinationally from the same register
module jk_flip_flop #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] JK,
    output logic       q,
    output logic       qb
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q;
        unique case (JK)
            2'b00:   state_d = state_q;
            2'b01:   state_d = 1'b0;
            2'b10:   state_d = 1'b1;
            2'b11:   state_d = ~state_q;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    // qb comes from the single register so q and qb can never disagree.
    assign q  = state_q;
    assign qb = ~state_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Scoreboard bench for jk_flip_flop: the stimulus process pushes expected q
// values into a queue; an independent monitor pops and compares them on the
// falling clk edge, or immediately when an asynchronous-reset check is posted.
module tb_jk_flip_flop;

    localparam logic RV = 1'b0;

    logic       clk;
    logic       rst_n;
    logic [1:0] JK;
    logic       q;
    logic       qb;

    typedef struct {
        logic  exp_q;
        string name;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      chk_ev;
    logic      m_q;
    int        n_pass;
    int        n_checks;

    jk_flip_flop #(
        .RESET_VALUE(RV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .JK   (JK),
        .q    (q),
        .qb   (qb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic jk_next(input logic cur, input logic [1:0] jk);
        case (jk)
            2'b00:   return cur;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~cur;
        endcase
    endfunction

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, required %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: q is stable at the falling edge and right after an async event.
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() != 0) begin
                sb_entry_t e;
                e = sb.pop_front();
                check({e.name, ".q"}, q, e.exp_q);
                check({e.name, ".qb"}, qb, ~e.exp_q);
            end
        end
    end

    task automatic push(input string name);
        sb_entry_t e;
        e.exp_q = m_q;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Model one rising edge using the JK value present before the edge.
    task automatic on_edge(input string name);
        @(posedge clk);
        if (rst_n) m_q = jk_next(m_q, JK);
        else       m_q = RV;
        push(name);
    endtask

    // Change JK at the falling edge, well away from the sampling edge.
    task automatic step(input logic [1:0] jk, input string name);
        @(negedge clk);
        JK = jk;
        on_edge(name);
    endtask

    initial begin
        logic [1:0] pattern [4];
        pattern[0] = 2'b00;
        pattern[1] = 2'b01;
        pattern[2] = 2'b10;
        pattern[3] = 2'b11;
        n_pass   = 0;
        n_checks = 0;

        // Reset held at time zero with toggle requested: q must not move.
        rst_n = 1'b0;
        JK    = 2'b11;
        m_q   = RV;
        #1;
        push("rst_async");
        -> chk_ev;
        repeat (3) on_edge("rst_hold");

        @(negedge clk);
        #3 rst_n = 1'b1;

        // Set, then hold.
        step(2'b10, "set");
        repeat (3) step(2'b00, "hold");

        // Reset twice (idempotent).
        step(2'b01, "reset1");
        step(2'b01, "reset2");

        // Toggle four times: 1,0,1,0.
        repeat (4) step(2'b11, "toggle");

        // JK cycles every 30 ns against a 20 ns clock, changes off the edges.
        @(negedge clk);
        #5;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    JK = pattern[k % 4];
                    #30;
                end
            end
        join_none
        repeat (12) on_edge("cycle");
        wait fork;

        // Asynchronous reset mid-cycle from q=1.
        step(2'b10, "pre_rst");
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        JK    = 2'b11;
        m_q   = RV;
        #1;
        push("rst_mid");
        -> chk_ev;
        on_edge("rst_across_edge");
        @(negedge clk);
        #3 rst_n = 1'b1;
        on_edge("post_rst_toggle");

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending entries, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
